hdc_dataset_sequencer: RTL and testbench

Controller that walks a labelled sample memory and drives the one-shot HDC pipeline through a full train-then-test run. For each training sample it fetches the feature-row index and class label, then pulses `start_mapping`. It waits for per-sample completion before moving on. After the last training sample it pulses `training_dataset_finished`, then repeats the loop for the test set. It ends with `testing_dataset_finished` and a final `done` handshake. It sits between the testbench/host sample store and the HDC top-level, replacing hand-driven control pins.

---
 rtl/hdc_dataset_sequencer.sv | 126 ++++++++++++
 tb/tb_hdc_dataset_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_dataset_sequencer.sv
// hdc_dataset_sequencer: walks the labelled sample store through a train-then-test run of the one-shot HDC pipeline
module hdc_dataset_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int LABEL_W = 5
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  train_count,
  input  logic [ADDR_W-1:0]  test_count,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_valid,
  input  logic [LABEL_W-1:0] mem_rd_label,
  output logic               start_mapping,
  output logic [LABEL_W-1:0] class_select_bits,
  input  logic               sample_done,
  output logic               training_dataset_finished,
  output logic               testing_dataset_finished,
  input  logic               oneshot_hdc_done,
  output logic               busy,
  output logic               phase_test,
  output logic               done
);
  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] FETCH       = 4'd1;
  localparam logic [3:0] WAIT_DATA   = 4'd2;
  localparam logic [3:0] ISSUE       = 4'd3;
  localparam logic [3:0] WAIT_SAMPLE = 4'd4;
  localparam logic [3:0] TRAIN_FIN   = 4'd5;
  localparam logic [3:0] TEST_FIN    = 4'd6;
  localparam logic [3:0] WAIT_HDC    = 4'd7;
  localparam logic [3:0] DONE        = 4'd8;

  logic [3:0]         state, nxt;
  logic [ADDR_W-1:0]  tc, sc, idx, nxt_tc, nxt_sc, nxt_idx;
  logic               nxt_phase;
  logic [LABEL_W-1:0] nxt_label;
  logic               rd_q, map_q, trf_q, tef_q, done_q;

  // pulse registers stay set while frozen; gating with en and abort keeps them
  // quiet until the pulse can really be delivered
  assign mem_rd_en                 = rd_q   & en & ~abort;
  assign start_mapping             = map_q  & en & ~abort;
  assign training_dataset_finished = trf_q  & en & ~abort;
  assign testing_dataset_finished  = tef_q  & en & ~abort;
  assign done                      = done_q & en & ~abort;

  // next-state, sample index, phase and label selection
  always_comb begin
    nxt       = state;
    nxt_idx   = idx;
    nxt_tc    = tc;
    nxt_sc    = sc;
    nxt_phase = phase_test;
    nxt_label = class_select_bits;
    if (abort) begin
      nxt       = IDLE;
      nxt_phase = 1'b0;
      nxt_label = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nxt_tc    = train_count;
          nxt_sc    = test_count;
          nxt_idx   = '0;
          nxt_phase = 1'b0;
          nxt       = (train_count == '0) ? TRAIN_FIN : FETCH;
        end
        FETCH:     nxt = WAIT_DATA;
        WAIT_DATA: if (mem_rd_valid) begin
          nxt_label = mem_rd_label;
          nxt       = ISSUE;
        end
        ISSUE:       nxt = WAIT_SAMPLE;
        WAIT_SAMPLE: if (sample_done) begin
          nxt_idx = idx + ADDR_W'(1);
          nxt     = (nxt_idx != (phase_test ? sc : tc)) ? FETCH : (phase_test ? TEST_FIN : TRAIN_FIN);
        end
        TRAIN_FIN: begin
          nxt_phase = 1'b1;
          nxt_idx   = '0;
          nxt       = (sc == '0) ? TEST_FIN : FETCH;
        end
        TEST_FIN: nxt = WAIT_HDC;
        WAIT_HDC: nxt = oneshot_hdc_done ? DONE : WAIT_HDC;
        default:  nxt = IDLE;
      endcase
    end
  end

  // state and registered outputs, all frozen while en is low
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state             <= IDLE;
      tc                <= '0;
      sc                <= '0;
      idx               <= '0;
      phase_test        <= 1'b0;
      class_select_bits <= '0;
      mem_rd_addr       <= '0;
      busy              <= 1'b0;
      rd_q              <= 1'b0;
      map_q             <= 1'b0;
      trf_q             <= 1'b0;
      tef_q             <= 1'b0;
      done_q            <= 1'b0;
    end else if (en) begin
      state             <= nxt;
      tc                <= nxt_tc;
      sc                <= nxt_sc;
      idx               <= nxt_idx;
      phase_test        <= nxt_phase;
      class_select_bits <= nxt_label;
      busy              <= nxt != IDLE;
      rd_q              <= nxt == FETCH;
      map_q             <= nxt == ISSUE;
      trf_q             <= nxt == TRAIN_FIN;
      tef_q             <= nxt == TEST_FIN;
      done_q            <= nxt == DONE;
      if (nxt == FETCH) mem_rd_addr <= nxt_phase ? nxt_tc + nxt_idx : nxt_idx;
    end
  end
endmodule

// File: tb/tb_hdc_dataset_sequencer.sv
// tb_hdc_dataset_sequencer: table-driven runs with a memory/HDC responder and label scoreboard
`timescale 1ns/1ps
module tb_hdc_dataset_sequencer;
  localparam int AW = 11;
  localparam int LW = 5;

  logic clk = 0, nrst = 0, en = 0, start = 0, abort = 0;
  logic mem_rd_valid = 0, sample_done = 0, oneshot_hdc_done = 0;
  logic [AW-1:0] train_count = 0, test_count = 0, mem_rd_addr;
  logic [LW-1:0] mem_rd_label = 0, class_select_bits;
  logic mem_rd_en, start_mapping, training_dataset_finished, testing_dataset_finished;
  logic busy, phase_test, done;

  int checks = 0, errors = 0;
  logic [LW-1:0] mem [0:(1<<AW)-1];

  typedef struct { int tc; int sc; int lat; int dly; int spur; int gate; int abort_at; } cfg_t;
  cfg_t tbl[7];
  logic [AW-1:0] exp_addr[$];
  logic [LW-1:0] exp_lbl[$];

  hdc_dataset_sequencer #(.ADDR_W(AW), .LABEL_W(LW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .abort(abort),
    .train_count(train_count), .test_count(test_count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_label(mem_rd_label),
    .start_mapping(start_mapping), .class_select_bits(class_select_bits),
    .sample_done(sample_done),
    .training_dataset_finished(training_dataset_finished),
    .testing_dataset_finished(testing_dataset_finished),
    .oneshot_hdc_done(oneshot_hdc_done),
    .busy(busy), .phase_test(phase_test), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, mem_rd_en, mem_rd_addr, start_mapping, class_select_bits,
            training_dataset_finished, testing_dataset_finished, busy, phase_test, done};
  endfunction

  task automatic run(input cfg_t c);
    int rd_cnt = 0, dn_cnt = 0, hdc_cnt = 0, en_cnt = 0;
    int maps = 0, sdone = 0, sd_c = -1, trf_c = -1, tef_c = -1, hdc_c = -1, done_c = -1, abort_c = -1;
    bit gate_pend = 0, gated = 0, gated_ok = 1, stable = 1, fin = 0, spur_now;
    logic [AW-1:0] rd_a = 0;
    logic [LW-1:0] cur = 0;
    for (int k = 0; k < c.tc + c.sc; k++) begin
      exp_addr.push_back(AW'(k));
      exp_lbl.push_back(mem[AW'(k)]);
    end
    train_count = AW'(c.tc);
    test_count  = AW'(c.sc);
    start = 1;
    @(posedge clk);
    #0.5 start = 0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #0.5;
      end
      if (en_cnt > 0) begin
        en_cnt--;
        if (en_cnt == 0) en = 1;
      end
      if (gate_pend) begin
        en = 0;
        en_cnt = 11;
        gate_pend = 0;
      end
      #0.5;
      if (cyc == 0) begin
        chk("busy_after_start", busy, 1);
        chk("rd_en_after_start", mem_rd_en, c.tc > 0);
      end
      if (!en && start_mapping) gated_ok = 0;
      if (gated && en && en_cnt == 0 && cyc == sd_c + 100000) gated_ok = 0;
      if (abort_c >= 0 && cyc == abort_c + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_phase", phase_test, 0);
        chk("abort_label", class_select_bits, 0);
        chk("abort_no_test_fin", tef_c, -1);
        abort = 0;
        exp_addr.delete();
        exp_lbl.delete();
        fin = 1;
      end
      if (mem_rd_en) begin
        rd_a = mem_rd_addr;
        if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
        rd_cnt = c.lat + 1;
      end
      if (start_mapping) begin
        maps++;
        if (gated) chk("map_after_en", en_cnt, 0);
        if (exp_lbl.size() == 0) chk("map_extra", 1, 0);
        else begin
          cur = exp_lbl.pop_front();
          chk("map_label", class_select_bits, cur);
        end
        chk("map_phase", phase_test, maps > c.tc);
        dn_cnt = c.dly + 1;
        stable = 1;
        if (maps == c.abort_at) begin
          abort = 1;
          #0.1;
          chk("abort_gate", start_mapping, 0);
          abort_c = cyc;
          dn_cnt = 0;
        end
      end
      if (dn_cnt > 0 && class_select_bits !== cur) stable = 0;
      if (training_dataset_finished) begin
        chk("trf_after_samples", sdone, c.tc);
        if (c.tc > 0) chk("trf_time", cyc, sd_c + 1);
        trf_c = cyc;
      end
      if (testing_dataset_finished) begin
        chk("tef_after_samples", sdone, c.tc + c.sc);
        if (c.sc == 0) chk("fin_consecutive", cyc, trf_c + 1);
        tef_c = cyc;
        hdc_cnt = 4;
      end
      if (done) begin
        chk("done_time", cyc, hdc_c + 1);
        done_c = cyc;
        oneshot_hdc_done = 0;
      end
      if (done_c >= 0 && cyc == done_c + 1) begin
        chk("busy_fall", busy, 0);
        fin = 1;
      end
      spur_now = c.spur != 0 && rd_cnt > 0;
      mem_rd_valid = 0;
      mem_rd_label = LW'($urandom);
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rd_valid = 1;
          mem_rd_label = mem[rd_a];
          if (c.gate != 0 && !gated) begin
            gate_pend = 1;
            gated = 1;
          end
        end
      end
      sample_done = spur_now;
      if (dn_cnt > 0) begin
        dn_cnt--;
        if (dn_cnt == 0) begin
          sample_done = 1;
          sdone++;
          sd_c = cyc;
          chk("label_stable", stable, 1);
        end
      end
      if (hdc_cnt > 0) begin
        hdc_cnt--;
        if (hdc_cnt == 0) begin
          oneshot_hdc_done = 1;
          hdc_c = cyc;
        end
      end
    end
    chk("run_complete", fin, 1);
    if (c.abort_at == 0) chk("all_mapped", exp_lbl.size(), 0);
    if (c.gate != 0) chk("no_map_while_en_low", gated_ok, 1);
    exp_addr.delete();
    exp_lbl.delete();
    mem_rd_valid = 0;
    sample_done = 0;
    oneshot_hdc_done = 0;
    abort = 0;
    en = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem[k] = LW'($urandom);
    mem[0] = 5'd4; mem[1] = 5'd7; mem[2] = 5'd1; mem[3] = 5'd0; mem[4] = 5'd25;
    tbl[0] = '{3, 2, 1, 4, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{2, 2, 5, 40, 1, 0, 0};
    tbl[3] = '{1, 1, 1, 3, 0, 1, 0};
    tbl[4] = '{2, 3, 2, 3, 0, 0, 4};
    tbl[5] = '{3, 2, 1, 4, 0, 0, 0};
    tbl[6] = '{2047, 2, 1, 1, 0, 0, 0};
    #12;
    chk("reset_outputs", outs(), 0);
    @(posedge clk);
    #1 nrst = 1;
    en = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run(tbl[i]);
    train_count = 2;
    test_count = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("rst_seq_fetch", mem_rd_en, 1);
    @(posedge clk);
    #1 mem_rd_valid = 1;
    mem_rd_label = 5'd9;
    @(posedge clk);
    #1 mem_rd_valid = 0;
    chk("rst_seq_issue", start_mapping, 1);
    @(posedge clk);
    #1 chk("rst_seq_label", class_select_bits, 9);
    #2 nrst = 0;
    #0.1 chk("async_reset_outputs", outs(), 0);
    start = 1;
    @(posedge clk);
    #1 chk("start_in_reset", busy, 0);
    start = 0;
    nrst = 1;
    @(posedge clk);
    #1 chk("idle_after_reset", outs(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
